// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and hazard helpers for the five-stage pipeline sequencer.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  // x0 is hardwired zero, so a load targeting it can never create a dependency.
  function automatic logic load_use_hit(
    input logic       dmrd_ex,
    input logic       ruwr_ex,
    input logic [4:0] rd_ex,
    input logic [4:0] rs1_de,
    input logic       uses_rs1_de,
    input logic [4:0] rs2_de,
    input logic       uses_rs2_de
  );
    return dmrd_ex && ruwr_ex && (rd_ex != REG_X0) &&
           ((uses_rs1_de && (rs1_de == rd_ex)) || (uses_rs2_de && (rs2_de == rd_ex)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter for performance debug.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] value
);
  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (inc && (value_q != '1)) value_d = value_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

  assign value = value_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: stage enables/clears for init, load-use stalls,
// EX branch flushes and data-memory waits with timeout.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_de,
  input  logic [4:0]       rs2_de,
  input  logic             uses_rs1_de,
  input  logic             uses_rs2_de,
  input  logic [4:0]       rd_ex,
  input  logic             RuWr_ex,
  input  logic             DMRd_ex,
  input  logic             NextPCSrc,
  input  logic             dm_req_me,
  input  logic             dm_ack,
  output logic             en_pc_fe,
  output logic             en_de,
  output logic             en_ex,
  output logic             en_me,
  output logic             en_wb,
  output logic             clr_de,
  output logic             clr_ex,
  output logic             clr_me,
  output logic             clr_wb,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);
  localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [IW-1:0] INIT_LOAD = IW'(INIT_CYCLES - 1);
  localparam logic [WW-1:0] TIMEOUT_V = WW'(MEM_TIMEOUT);

  state_e        state_q, state_d;
  logic [IW-1:0] init_q, init_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          mem_err_q, mem_err_d;
  logic          freeze, run_eval, hit;
  logic          stall_inc, flush_inc;

  assign hit = load_use_hit(DMRd_ex, RuWr_ex, rd_ex, rs1_de, uses_rs1_de, rs2_de, uses_rs2_de);

  always_comb begin
    state_d   = state_q;
    init_d    = init_q;
    wait_d    = wait_q;
    mem_err_d = mem_err_q;
    freeze    = 1'b0;
    run_eval  = 1'b0;
    case (state_q)
      INIT: begin
        if (init_q == '0) state_d = RUN;
        else              init_d  = init_q - IW'(1);
      end
      RUN: begin
        if (dm_req_me && !dm_ack) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
          wait_d  = WW'(1);
        end else begin
          run_eval = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Release (ack or timeout) re-evaluates hazards against the frozen EX/DE contents.
        if (dm_ack) begin
          run_eval = 1'b1;
          state_d  = RUN;
        end else if (wait_q == TIMEOUT_V) begin
          run_eval  = 1'b1;
          state_d   = RUN;
          mem_err_d = 1'b1;
        end else begin
          freeze = 1'b1;
          wait_d = wait_q + WW'(1);
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    en_pc_fe = 1'b0; en_de = 1'b0; en_ex = 1'b0; en_me = 1'b0; en_wb = 1'b0;
    clr_de   = 1'b1; clr_ex = 1'b1; clr_me = 1'b1; clr_wb = 1'b1;
    if (freeze) begin
      en_wb  = 1'b1;
      clr_de = 1'b0; clr_ex = 1'b0; clr_me = 1'b0;
    end else if (run_eval) begin
      en_pc_fe = 1'b1; en_de = 1'b1; en_ex = 1'b1; en_me = 1'b1; en_wb = 1'b1;
      clr_de   = 1'b0; clr_ex = 1'b0; clr_me = 1'b0; clr_wb = 1'b0;
      // The DE instruction is wrong-path on a taken branch, so flush beats stall.
      if (NextPCSrc) begin
        clr_de = 1'b1; clr_ex = 1'b1;
      end else if (hit) begin
        en_pc_fe = 1'b0; en_de = 1'b0; clr_ex = 1'b1;
      end
    end
  end

  assign flush_inc = run_eval && NextPCSrc;
  assign stall_inc = run_eval && !NextPCSrc && hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT;
      init_q    <= INIT_LOAD;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      init_q    <= init_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst_n(rst_n), .inc(stall_inc), .value(stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst_n(rst_n), .inc(flush_inc), .value(flush_cnt));
  sat_counter #(.W(CNT_W)) u_wait_cnt  (.clk(clk), .rst_n(rst_n), .inc(freeze),    .value(wait_cnt));
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: init, stalls, flushes, memory waits and timeout.
module tb_pipeline_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_de, rs2_de, rd_ex;
  logic        uses_rs1_de, uses_rs2_de, RuWr_ex, DMRd_ex, NextPCSrc, dm_req_me, dm_ack;
  logic        en_pc_fe, en_de, en_ex, en_me, en_wb;
  logic        clr_de, clr_ex, clr_me, clr_wb, mem_err;
  logic [15:0] stall_cnt, flush_cnt, wait_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.INIT_CYCLES(2), .MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_de(rs1_de), .rs2_de(rs2_de), .uses_rs1_de(uses_rs1_de), .uses_rs2_de(uses_rs2_de),
    .rd_ex(rd_ex), .RuWr_ex(RuWr_ex), .DMRd_ex(DMRd_ex), .NextPCSrc(NextPCSrc),
    .dm_req_me(dm_req_me), .dm_ack(dm_ack),
    .en_pc_fe(en_pc_fe), .en_de(en_de), .en_ex(en_ex), .en_me(en_me), .en_wb(en_wb),
    .clr_de(clr_de), .clr_ex(clr_ex), .clr_me(clr_me), .clr_wb(clr_wb),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
  );

  wire [4:0] en  = {en_pc_fe, en_de, en_ex, en_me, en_wb};
  wire [3:0] clr = {clr_de, clr_ex, clr_me, clr_wb};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    rs1_de = 5'd0; rs2_de = 5'd0; rd_ex = 5'd0;
    uses_rs1_de = 1'b0; uses_rs2_de = 1'b0; RuWr_ex = 1'b0; DMRd_ex = 1'b0;
    NextPCSrc = 1'b0; dm_req_me = 1'b0; dm_ack = 1'b0;
  endtask

  task automatic load_use_vec(input logic [4:0] rd);
    DMRd_ex = 1'b1; RuWr_ex = 1'b1; rd_ex = rd; rs2_de = 5'd5; uses_rs2_de = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #1;
    chk("reset_en", 32'(en), 32'h00);
    chk("reset_clr", 32'(clr), 32'hF);
    chk("reset_err", 32'(mem_err), 32'h0);
    chk("reset_cnts", {stall_cnt, flush_cnt} | 32'(wait_cnt), 32'h0);

    #11 rst_n = 1'b1;
    tick();
    chk("init1_en", 32'(en), 32'h00);
    chk("init1_clr", 32'(clr), 32'hF);
    tick();
    chk("run_en", 32'(en), 32'h1F);
    chk("run_clr", 32'(clr), 32'h0);

    // load-use on rs2
    load_use_vec(5'd5); #1;
    chk("lu_en", 32'(en), 32'h07);
    chk("lu_clr", 32'(clr), 32'h4);
    tick(); idle(); #1;
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    chk("lu_after_en", 32'(en), 32'h1F);

    // rd_ex == x0 never stalls
    load_use_vec(5'd0); #1;
    chk("x0_en", 32'(en), 32'h1F);
    chk("x0_clr", 32'(clr), 32'h0);
    tick(); idle(); #1;
    chk("x0_stall_cnt", 32'(stall_cnt), 32'd1);

    // branch flush
    NextPCSrc = 1'b1; #1;
    chk("br_en", 32'(en), 32'h1F);
    chk("br_clr", 32'(clr), 32'hC);
    tick(); idle(); #1;
    chk("br_flush_cnt", 32'(flush_cnt), 32'd1);

    // branch + load-use: flush only
    NextPCSrc = 1'b1; load_use_vec(5'd5); #1;
    chk("brlu_en", 32'(en), 32'h1F);
    chk("brlu_clr", 32'(clr), 32'hC);
    tick(); idle(); #1;
    chk("brlu_flush_cnt", 32'(flush_cnt), 32'd2);
    chk("brlu_stall_cnt", 32'(stall_cnt), 32'd1);

    // memory wait, ack in the fourth cycle
    dm_req_me = 1'b1; #1;
    chk("mw0_en", 32'(en), 32'h01);
    chk("mw0_clr", 32'(clr), 32'h1);
    tick();
    chk("mw1_en", 32'(en), 32'h01);
    tick();
    chk("mw2_en", 32'(en), 32'h01);
    chk("mw2_clr", 32'(clr), 32'h1);
    tick(); dm_ack = 1'b1; #1;
    chk("mw_ack_en", 32'(en), 32'h1F);
    chk("mw_ack_clr", 32'(clr), 32'h0);
    tick(); idle(); #1;
    chk("mw_wait_cnt", 32'(wait_cnt), 32'd3);
    chk("mw_err", 32'(mem_err), 32'h0);
    chk("mw_run_en", 32'(en), 32'h1F);

    // branch held in EX during a memory wait
    dm_req_me = 1'b1; NextPCSrc = 1'b1; #1;
    chk("bmw0_en", 32'(en), 32'h01);
    chk("bmw0_clr", 32'(clr), 32'h1);
    tick();
    chk("bmw1_clr", 32'(clr), 32'h1);
    chk("bmw1_flush_cnt", 32'(flush_cnt), 32'd2);
    tick(); dm_ack = 1'b1; #1;
    chk("bmw_rel_en", 32'(en), 32'h1F);
    chk("bmw_rel_clr", 32'(clr), 32'hC);
    tick(); idle(); #1;
    chk("bmw_flush_cnt", 32'(flush_cnt), 32'd3);
    chk("bmw_wait_cnt", 32'(wait_cnt), 32'd5);

    // timeout: 15 frozen cycles, forced advance in the 16th
    dm_req_me = 1'b1; #1;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("to_freeze%0d", i), 32'({en, clr}), 32'({5'h01, 4'h1}));
      tick();
    end
    chk("to_adv_en", 32'(en), 32'h1F);
    chk("to_adv_clr", 32'(clr), 32'h0);
    chk("to_adv_err", 32'(mem_err), 32'h0);
    tick(); idle(); #1;
    chk("to_err", 32'(mem_err), 32'h1);
    chk("to_wait_cnt", 32'(wait_cnt), 32'd20);
    chk("to_run_en", 32'(en), 32'h1F);
    tick(); tick();
    chk("to_err_sticky", 32'(mem_err), 32'h1);

    // asynchronous reset in the middle of a memory wait
    dm_req_me = 1'b1;
    tick();
    chk("pre_rst_en", 32'(en), 32'h01);
    rst_n = 1'b0; #1;
    chk("mid_rst_en", 32'(en), 32'h00);
    chk("mid_rst_clr", 32'(clr), 32'hF);
    chk("mid_rst_err", 32'(mem_err), 32'h0);
    chk("mid_rst_cnts", {stall_cnt, flush_cnt} | 32'(wait_cnt), 32'h0);
    idle();
    #10 rst_n = 1'b1;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencer for the five-stage pipeline (FE/DE/EX/ME/WB). It generates every stage-register enable and clear, and replaces the ad-hoc hazard wiring currently spread across the top level. It handles:
- reset initialisation,
- load-use stalls,
- branch/jump flushes from EX,
- multi-cycle data-memory waits, with a timeout.

Saturating counters for stall, flush and wait cycles support performance debug.

## Interface
Parameters:
- INIT_CYCLES, 2: cycles all stage registers are held clear after reset.
- MEM_TIMEOUT, 15: maximum cycles spent in MEM_WAIT before forced advance.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  pipeline clock; one clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rs1_de, rs2_de  in  5 each  source registers of the instruction in DE.
- uses_rs1_de, uses_rs2_de  in  1 each  DE instruction actually reads rs1/rs2.
- rd_ex  in  5  destination register of the instruction in EX.
- RuWr_ex  in  1  EX instruction writes the register unit.
- DMRd_ex  in  1  EX instruction is a load.
- NextPCSrc  in  1  branch/jump taken, resolved in EX.
- dm_req_me  in  1  ME instruction accesses data memory.
- dm_ack  in  1  data memory completes the access this cycle.
- en_pc_fe, en_de, en_ex, en_me, en_wb  out  1 each  load enables for the PC and for the DE/EX/ME/WB registers.
- clr_de, clr_ex, clr_me, clr_wb  out  1 each  synchronous bubble insert into the named stage register. Clear has priority over enable.
- mem_err  out  1  sticky; set when a memory timeout occurs.
- stall_cnt, flush_cnt, wait_cnt  out  CNT_W each  saturating event counters.

## Operation
- States: INIT, RUN, MEM_WAIT. Outputs are Mealy: they depend on the current state and the current-cycle inputs.
- **INIT:**
  - All en_* = 0 and all clr_* = 1.
  - A down-counter loaded with INIT_CYCLES-1 decrements each cycle; at 0 the next state is RUN.
- **RUN, default:** all en_* = 1, all clr_* = 0.
- **RUN, priority order (highest first):**
  1. mem: dm_req_me && !dm_ack. Outputs: en_pc_fe = en_de = en_ex = en_me = 0, clr_wb = 1. Next state MEM_WAIT; wait counter := 1.
  2. branch: NextPCSrc. Outputs: clr_de = clr_ex = 1, all enables 1. flush_cnt += 1.
  3. load-use: DMRd_ex && RuWr_ex && rd_ex != 0 && ((uses_rs1_de && rs1_de == rd_ex) || (uses_rs2_de && rs2_de == rd_ex)). Outputs: en_pc_fe = en_de = 0, clr_ex = 1. stall_cnt += 1.
- **MEM_WAIT:**
  - Holding: same outputs as the mem case; wait_cnt += 1 each cycle.
  - dm_ack: outputs revert to RUN evaluation, so branch and load-use are re-checked with the frozen EX/DE contents. Next state RUN.
  - Timeout (wait counter == MEM_TIMEOUT without dm_ack): set mem_err, force one advance cycle exactly as if dm_ack were seen, next state RUN.
- Counters saturate at 2^CNT_W-1. mem_err clears only on reset.

## Timing
- Reset values:
  - state INIT;
  - en_* = 0, clr_* = 1;
  - mem_err = 0;
  - all counters 0.
- Assertion of rst_n low forces these values immediately, including in the middle of MEM_WAIT or a stall.
- First RUN cycle is the (INIT_CYCLES+1)th rising edge after rst_n rises.
- Hazard response latency is 0 cycles (combinational). State and counters update on the rising edge of clk.
- Load-use costs exactly 1 bubble; branch costs 2 squashed instructions.
- Simultaneous branch and memory wait: the freeze wins. NextPCSrc persists from the frozen EX stage and takes effect in the release cycle.
- Simultaneous branch and load-use: the flush wins, because the stalled DE instruction is wrong-path. No stall is counted.
- rd_ex == 0 never stalls.

## Structure
- pipeline_ctrl_pkg holds:
  - the state enum typedef (INIT, RUN, MEM_WAIT);
  - the localparam REG_X0 = 5'd0;
  - a function computing the load-use hit.
- One sub-module, sat_counter (parameter W; ports clk, rst_n, inc, value), instantiated three times.
- The FSM, init counter and wait counter live in pipeline_ctrl.

## Test plan
- Reset release with INIT_CYCLES=2 -> clr_* = 1 for 2 cycles, then all en_* = 1, clr_* = 0; rst_n low mid-run restores the reset values the same cycle.
- Load-use: DMRd_ex = RuWr_ex = 1, rd_ex = 5, rs2_de = 5, uses_rs2_de = 1 -> en_pc_fe = en_de = 0, clr_ex = 1 for one cycle; stall_cnt = 1. The same stimulus with rd_ex = 0 -> no stall.
- NextPCSrc = 1 for one cycle -> clr_de = clr_ex = 1, en_pc_fe = 1; flush_cnt = 1. Adding a load-use hit in the same cycle -> still flush only, stall_cnt unchanged.
- dm_req_me = 1 with dm_ack after 3 cycles -> freeze for 3 cycles with clr_wb = 1, advance in the ack cycle; wait_cnt = 3; mem_err = 0.
- dm_ack never asserted, MEM_TIMEOUT = 15 -> forced advance after 15 cycles, mem_err = 1 and held until reset.
- Branch during MEM_WAIT -> no flush while frozen; clr_de = clr_ex = 1 in the release cycle.
